mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, synchronous-read block RAM between instruction fetch (IF, read-only) and the MEM stage (data read/write).
- Grants one requester per cycle and drives the RAM command.
- Routes the 1-cycle-later read data back to the issuing requester and holds it stable.
- Produces stall signals that the core's hazard logic ORs into pcStall/ifidStall.

Parameters:
ADDR_W, 12, word-address width of the shared RAM
DATA_W, 32, data width; byte enables = DATA_W/8
STARVE_LIMIT, 4, consecutive IF denials before forced IF grant (ARB_FAIR_EN only)

Ports:
clk  input  1  core clock; all state on rising edge
rst  input  1  synchronous, active-high reset
ifReq  input  1  IF read request
ifAddr  input  ADDR_W  IF word address
ifGnt  output  1  IF request accepted this cycle
ifRvalid  output  1  ifRdata updated this cycle
ifRdata  output  DATA_W  IF read data, held until next IF read returns
ifStall  output  1  ifReq & ~ifGnt
dReq  input  1  data request
dWe  input  1  1 = write, 0 = read
dBe  input  DATA_W/8  write byte enables
dAddr  input  ADDR_W  data word address
dWdata  input  DATA_W  write data
dGnt  output  1  data request accepted this cycle
dRvalid  output  1  dRdata updated this cycle (reads only)
dRdata  output  DATA_W  data read result, held until next data read returns
dStall  output  1  dReq & ~dGnt
memEn  output  1  RAM enable
memWe  output  DATA_W/8  RAM byte write enables
memAddr  output  ADDR_W  RAM address
memWdata  output  DATA_W  RAM write data
memRdata  input  DATA_W  RAM read data, valid the cycle after a read enable

Behaviour:
- Grant is combinational in the request cycle. Default priority: data over IF, because the MEM-stage instruction is older.
  - Both requesting: dGnt=1, ifGnt=0.
  - Only one requesting: that one is granted.
- RAM command mux is combinational from the grant.
  - Data granted: memEn=1; memAddr=dAddr; memWdata=dWdata; memWe=dWe?dBe:0.
  - IF granted: memEn=1; memAddr=ifAddr; memWe=0.
  - No grant: memEn=0, memWe=0, memAddr/memWdata=0.
- A write with dBe=0 is still granted (memEn=1, memWe=0) and produces no rvalid.
- Read tracking FSM, registered, tags the outstanding read:
  - States: IDLE, IF_RD, D_RD.
  - Next state: data read granted -> D_RD; IF granted -> IF_RD; otherwise IDLE. This applies from any state, so back-to-back reads are fully pipelined at 1 per cycle.
- Read return: in IF_RD, ifRvalid=1 and ifRdata<=memRdata. In D_RD, dRvalid=1 and dRdata<=memRdata.
  - Holding registers are written directly from memRdata and also drive the outputs; the value is visible in the return cycle.
  - The value stays stable afterwards until the next return to the same requester.
- Latency: grant in cycle N -> rvalid and data in cycle N+1.
- Write then read to the same address in consecutive cycles returns the new data (RAM is read-first-per-cycle; the write completes before the read).
- Reset: state=IDLE; ifRvalid=dRvalid=0; ifRdata=dRdata=0; starvation counter=0.
  - A read granted in the cycle rst is high is discarded: no rvalid in the following cycle.
  - Combinational outputs still follow the grant rule during rst, but grants are forced to 0 while rst=1.
- ifStall/dStall are purely combinational; the core must hold its request stable while stalled.

Optional Feature:
- ARB_FAIR_EN defined:
  - A saturating counter (width clog2(STARVE_LIMIT+1)) increments each cycle ifReq=1 and ifGnt=0.
  - It clears when IF is granted or ifReq=0.
  - When counter==STARVE_LIMIT, IF wins the next contention (one grant); dStall=1 that cycle.
- ARB_FAIR_EN undefined: strict data priority; no counter logic is synthesised.

Decomposition:
- Shared package (mem_arb_pkg): FSM state encoding (IDLE/IF_RD/D_RD) and the owner-tag constants.
- ADDR_W/DATA_W stay as parameters.
- No sub-module required. The starvation counter may be a small sub-module, arb_starve_ctr, instantiated only under ARB_FAIR_EN.

Test Plan:
- IF-only reads at 0x000..0x003 on consecutive cycles, RAM preloaded with word=addr*4 -> ifGnt=1 each cycle; ifRvalid one cycle later; ifRdata=0x0,0x4,0x8,0xC; ifStall=0.
- ifReq=dReq=1 with dWe=0, dAddr=0x010 (RAM=0xDEADBEEF) -> dGnt=1, ifStall=1; next cycle dRvalid=1, dRdata=0xDEADBEEF, ifRvalid=0, ifRdata unchanged.
- Data write 0x11223344 to 0x020 with dBe=4'b0101, old word 0xAAAAAAAA; then data read 0x020 -> dRdata=0xAA22AA44; no rvalid after the write.
- IF read granted in cycle N with rst=1 in cycle N+1 -> ifRvalid=0 in N+1; all outputs zero; FSM IDLE.
- Without ARB_FAIR_EN, dReq held high for 10 cycles with ifReq=1 -> ifGnt=0 for all 10 cycles.
- With ARB_FAIR_EN and STARVE_LIMIT=4, same stimulus -> ifGnt=1 in cycle 5, dStall=1 that cycle; pattern repeats every 5 cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for mem_port_arbiter: read-tracking FSM encoding and grant owner tags.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StIfRd = 2'd1,
        StDRd  = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        OwnerNone = 2'd0,
        OwnerIf   = 2'd1,
        OwnerD    = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response and RAM command bundle for mem_port_arbiter.
// slave = arbiter view, master = core/RAM view.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
);
    logic                  ifReq;
    logic [ADDR_W-1:0]     ifAddr;
    logic                  ifGnt;
    logic                  ifRvalid;
    logic [DATA_W-1:0]     ifRdata;
    logic                  ifStall;

    logic                  dReq;
    logic                  dWe;
    logic [DATA_W/8-1:0]   dBe;
    logic [ADDR_W-1:0]     dAddr;
    logic [DATA_W-1:0]     dWdata;
    logic                  dGnt;
    logic                  dRvalid;
    logic [DATA_W-1:0]     dRdata;
    logic                  dStall;

    logic                  memEn;
    logic [DATA_W/8-1:0]   memWe;
    logic [ADDR_W-1:0]     memAddr;
    logic [DATA_W-1:0]     memWdata;
    logic [DATA_W-1:0]     memRdata;

    modport slave (
        input  ifReq, ifAddr, dReq, dWe, dBe, dAddr, dWdata, memRdata,
        output ifGnt, ifRvalid, ifRdata, ifStall,
        output dGnt, dRvalid, dRdata, dStall,
        output memEn, memWe, memAddr, memWdata
    );

    modport master (
        output ifReq, ifAddr, dReq, dWe, dBe, dAddr, dWdata, memRdata,
        input  ifGnt, ifRvalid, ifRdata, ifStall,
        input  dGnt, dRvalid, dRdata, dStall,
        input  memEn, memWe, memAddr, memWdata
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read RAM port between IF (read-only) and MEM (read/write).
// Define ARB_FAIR_EN to add IF starvation protection (forced IF grant after STARVE_LIMIT denials).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
`ifdef ARB_FAIR_EN
    ,
    parameter int unsigned STARVE_LIMIT = 4
`endif
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned BE_W = DATA_W / 8;

    owner_e            owner;
    rd_state_e         state_q, state_d;
    logic              if_win;
    logic              if_ret, d_ret;
    logic [DATA_W-1:0] if_hold_q, d_hold_q;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [BE_W-1:0]   cmd_we;

`ifdef ARB_FAIR_EN
    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

    logic [CntW-1:0] starve_q, starve_d;

    assign if_win = (starve_q == CntW'(STARVE_LIMIT));

    always_comb begin
        starve_d = starve_q;
        if (!bus.ifReq || bus.ifGnt) begin
            starve_d = '0;
        end else if (starve_q != CntW'(STARVE_LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign if_win = 1'b0;
`endif

    // Data wins by default: the MEM-stage instruction is older than the fetch.
    always_comb begin
        owner = OwnerNone;
        if (rst) begin
            owner = OwnerNone;
        end else if (bus.ifReq && (!bus.dReq || if_win)) begin
            owner = OwnerIf;
        end else if (bus.dReq) begin
            owner = OwnerD;
        end
    end

    always_comb begin
        bus.memEn = 1'b0;
        cmd_we    = '0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        unique case (owner)
            OwnerD: begin
                bus.memEn = 1'b1;
                cmd_addr  = bus.dAddr;
                cmd_wdata = bus.dWdata;
                cmd_we    = bus.dWe ? bus.dBe : '0;
            end
            OwnerIf: begin
                bus.memEn = 1'b1;
                cmd_addr  = bus.ifAddr;
            end
            default: ;
        endcase
    end

    assign bus.memAddr  = cmd_addr;
    assign bus.memWdata = cmd_wdata;
    assign bus.memWe    = cmd_we;

    assign bus.ifGnt   = (owner == OwnerIf);
    assign bus.dGnt    = (owner == OwnerD);
    assign bus.ifStall = bus.ifReq & ~bus.ifGnt;
    assign bus.dStall  = bus.dReq & ~bus.dGnt;

    // Tags the read issued this cycle so its data is steered back next cycle.
    always_comb begin
        state_d = StIdle;
        if (owner == OwnerD && !bus.dWe) begin
            state_d = StDRd;
        end else if (owner == OwnerIf) begin
            state_d = StIfRd;
        end
    end

    assign if_ret = (state_q == StIfRd) && !rst;
    assign d_ret  = (state_q == StDRd) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            if_hold_q <= '0;
            d_hold_q  <= '0;
        end else begin
            state_q <= state_d;
            if (if_ret) begin
                if_hold_q <= bus.memRdata;
            end
            if (d_ret) begin
                d_hold_q <= bus.memRdata;
            end
        end
    end

    // Return data bypasses the holding register so it is visible in the return cycle.
    assign bus.ifRvalid = if_ret;
    assign bus.dRvalid  = d_ret;
    assign bus.ifRdata  = rst ? '0 : (if_ret ? bus.memRdata : if_hold_q);
    assign bus.dRdata   = rst ? '0 : (d_ret ? bus.memRdata : d_hold_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural read-first RAM and a return scoreboard.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Read-first synchronous RAM; contents loaded on the first clock edge.
    logic [31:0] ram [4096];
    logic        ram_loaded = 1'b0;
    logic [31:0] ram_rdata  = 32'h0;
    assign bus.memRdata = ram_rdata;

    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 32'(i * 4);
            ram[16]    <= 32'hDEADBEEF;
            ram[32]    <= 32'hAAAAAAAA;
            ram_loaded <= 1'b1;
        end else if (bus.memEn) begin
            ram_rdata <= ram[bus.memAddr];
            for (int b = 0; b < 4; b++)
                if (bus.memWe[b]) ram[bus.memAddr][8*b +: 8] <= bus.memWdata[8*b +: 8];
        end
    end

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] q_if[$];
    logic [31:0] q_d[$];
    logic [31:0] last_if = 32'h0;
    logic [31:0] last_d  = 32'h0;
    logic        exp_g;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic ir, input logic [11:0] ia, input logic dr, input logic dwe,
                         input logic [3:0] dbe, input logic [11:0] da, input logic [31:0] dwd);
        bus.ifReq  = ir;
        bus.ifAddr = ia;
        bus.dReq   = dr;
        bus.dWe    = dwe;
        bus.dBe    = dbe;
        bus.dAddr  = da;
        bus.dWdata = dwd;
        #1;
    endtask

    // A read pushed in the previous cycle must return now; otherwise data must hold.
    task automatic returns();
        logic [31:0] e;
        chk("ifRvalid", 32'(bus.ifRvalid), 32'(q_if.size() != 0));
        if (q_if.size() != 0) begin
            e = q_if.pop_front();
            last_if = e;
            chk("ifRdata", bus.ifRdata, e);
        end else begin
            chk("ifRdata_hold", bus.ifRdata, last_if);
        end
        chk("dRvalid", 32'(bus.dRvalid), 32'(q_d.size() != 0));
        if (q_d.size() != 0) begin
            e = q_d.pop_front();
            last_d = e;
            chk("dRdata", bus.dRdata, e);
        end else begin
            chk("dRdata_hold", bus.dRdata, last_d);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        returns();
    endtask

    initial begin
        drive(1'b1, 12'h0, 1'b0, 1'b0, 4'h0, 12'h0, 32'h0);
        chk("rst_ifGnt", 32'(bus.ifGnt), 32'h0);
        chk("rst_memEn", 32'(bus.memEn), 32'h0);
        chk("rst_ifStall", 32'(bus.ifStall), 32'h1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 12'h0, 1'b0, 1'b0, 4'h0, 12'h0, 32'h0);
        chk("reset_ifRvalid", 32'(bus.ifRvalid), 32'h0);
        chk("reset_dRvalid", 32'(bus.dRvalid), 32'h0);
        chk("reset_ifRdata", bus.ifRdata, 32'h0);
        chk("reset_dRdata", bus.dRdata, 32'h0);
        chk("reset_state", 32'(dut.state_q), 32'(StIdle));

        // Back-to-back IF reads.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 12'(i), 1'b0, 1'b0, 4'h0, 12'h0, 32'h0);
            chk("if_gnt", 32'(bus.ifGnt), 32'h1);
            chk("if_stall", 32'(bus.ifStall), 32'h0);
            chk("if_memAddr", 32'(bus.memAddr), 32'(i));
            chk("if_memWe", 32'(bus.memWe), 32'h0);
            q_if.push_back(32'(i * 4));
            step();
        end

        // Contention: data wins.
        drive(1'b1, 12'h5, 1'b1, 1'b0, 4'h0, 12'h010, 32'h0);
        chk("cont_dGnt", 32'(bus.dGnt), 32'h1);
        chk("cont_ifGnt", 32'(bus.ifGnt), 32'h0);
        chk("cont_ifStall", 32'(bus.ifStall), 32'h1);
        chk("cont_dStall", 32'(bus.dStall), 32'h0);
        chk("cont_memAddr", 32'(bus.memAddr), 32'h010);
        q_d.push_back(32'hDEADBEEF);
        step();

        // Byte-masked write then read-back.
        drive(1'b0, 12'h0, 1'b1, 1'b1, 4'b0101, 12'h020, 32'h11223344);
        chk("wr_dGnt", 32'(bus.dGnt), 32'h1);
        chk("wr_memWe", 32'(bus.memWe), 32'h5);
        chk("wr_memWdata", bus.memWdata, 32'h11223344);
        step();
        drive(1'b0, 12'h0, 1'b1, 1'b0, 4'h0, 12'h020, 32'h0);
        q_d.push_back(32'hAA22AA44);
        step();

        // Write with no byte enables still takes the port but changes nothing.
        drive(1'b0, 12'h0, 1'b1, 1'b1, 4'h0, 12'h030, 32'hFFFFFFFF);
        chk("be0_memEn", 32'(bus.memEn), 32'h1);
        chk("be0_memWe", 32'(bus.memWe), 32'h0);
        chk("be0_dGnt", 32'(bus.dGnt), 32'h1);
        step();
        drive(1'b0, 12'h0, 1'b1, 1'b0, 4'h0, 12'h030, 32'h0);
        q_d.push_back(32'h000000C0);
        step();

        drive(1'b0, 12'h0, 1'b0, 1'b0, 4'h0, 12'h0, 32'h0);
        chk("idle_memEn", 32'(bus.memEn), 32'h0);
        chk("idle_memAddr", 32'(bus.memAddr), 32'h0);
        chk("idle_memWdata", bus.memWdata, 32'h0);
        step();

        // IF read granted, then reset asserted in its return cycle.
        drive(1'b1, 12'h2, 1'b0, 1'b0, 4'h0, 12'h0, 32'h0);
        chk("pre_rst_ifGnt", 32'(bus.ifGnt), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b0, 12'h0, 1'b0, 1'b0, 4'h0, 12'h0, 32'h0);
        chk("rstret_ifRvalid", 32'(bus.ifRvalid), 32'h0);
        chk("rstret_ifRdata", bus.ifRdata, 32'h0);
        chk("rstret_dRdata", bus.dRdata, 32'h0);
        chk("rstret_memEn", 32'(bus.memEn), 32'h0);
        chk("rstret_stall", 32'({bus.ifStall, bus.dStall}), 32'h0);
        drive(1'b1, 12'h1, 1'b0, 1'b0, 4'h0, 12'h0, 32'h0);
        chk("rstret_ifGnt_forced", 32'(bus.ifGnt), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 12'h0, 1'b0, 1'b0, 4'h0, 12'h0, 32'h0);
        chk("postrst_ifRvalid", 32'(bus.ifRvalid), 32'h0);
        chk("postrst_ifRdata", bus.ifRdata, 32'h0);
        chk("postrst_state", 32'(dut.state_q), 32'(StIdle));
        last_if = 32'h0;
        last_d  = 32'h0;

        // Sustained contention for 10 cycles.
        for (int c = 0; c < 10; c++) begin
`ifdef ARB_FAIR_EN
            exp_g = ((c % 5) == 4);
`else
            exp_g = 1'b0;
`endif
            drive(1'b1, 12'h3, 1'b1, 1'b0, 4'h0, 12'h010, 32'h0);
            chk("starve_ifGnt", 32'(bus.ifGnt), 32'(exp_g));
            chk("starve_dGnt", 32'(bus.dGnt), 32'(!exp_g));
            chk("starve_dStall", 32'(bus.dStall), 32'(exp_g));
            if (exp_g) q_if.push_back(32'h0000000C);
            else q_d.push_back(32'hDEADBEEF);
            step();
        end

        drive(1'b0, 12'h0, 1'b0, 1'b0, 4'h0, 12'h0, 32'h0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
